// File: rtl/ad7760_bus_sched.sv
// AD7760 parallel-bus sequencer: converter reset, register-write queue drain,
// then run mode with conversion reads arbitrated ahead of queued writes.
module ad7760_bus_sched #(
   parameter int RST_LO_CYCLES = 2,
   parameter int RST_HI_CYCLES = 2,
   parameter int CS_CYCLES     = 8,
   parameter int GAP_CYCLES    = 8,
   parameter int SETTLE_CYCLES = 6,
   parameter int RD_CYCLES     = 2
) (
   input  logic        mclk,
   input  logic        i_rest,
   input  logic        start,
   input  logic        stop,
   input  logic        cfg_valid,
   output logic        cfg_ready,
   input  logic [15:0] cfg_addr,
   input  logic [15:0] cfg_data,
   input  logic        drdy_n,
   input  logic [15:0] adc_din,
   output logic [15:0] adc_dout,
   output logic        adc_oe,
   output logic        cs_n,
   output logic        r_n_w,
   output logic        o_rest_n,
   output logic        smp_valid,
   output logic [31:0] smp_data,
   output logic        busy,
   output logic [7:0]  ovf_cnt,
   output logic [3:0]  o_dbg_state
);

   typedef enum logic [3:0] {
      S_IDLE, S_RST_LO, S_RST_HI, S_CFG_CHK, S_WADR, S_WADR_GAP, S_WVAL,
      S_WVAL_GAP, S_SETTLE, S_RUN, S_RD_MSW, S_RD_GAP, S_RD_LSW, S_RD_DONE
   } state_t;

   localparam logic [7:0] LP_RST_LO = 8'(RST_LO_CYCLES - 1);
   localparam logic [7:0] LP_RST_HI = 8'(RST_HI_CYCLES - 1);
   localparam logic [7:0] LP_CS     = 8'(CS_CYCLES - 1);
   localparam logic [7:0] LP_GAP    = 8'(GAP_CYCLES - 1);
   localparam logic [7:0] LP_SETTLE = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] LP_RD     = 8'(RD_CYCLES - 1);

   state_t      r_state, w_next;
   logic [7:0]  r_cnt;
   logic        w_last;

   logic [15:0] r_q_addr [4];
   logic [15:0] r_q_data [4];
   logic [1:0]  r_wptr, r_rptr;
   logic [2:0]  r_count;
   logic        w_push, w_pop, w_empty;

   logic        r_sync1, r_sync2, r_sync3;
   logic        r_rd_pend, w_fall, w_rd_req, w_rd_enter;
   logic [7:0]  r_ovf;
   logic        r_run_mode;
   logic [15:0] r_msw;
   logic [31:0] r_smp_data;

   // cfg push handshake: an entry is taken on each mclk edge where
   // cfg_valid & cfg_ready; cfg_ready depends only on queue fill.
   assign w_push     = cfg_valid & cfg_ready;
   assign w_pop      = (r_state == S_WVAL_GAP) & w_last;
   assign w_empty    = (r_count == 3'd0);
   assign cfg_ready  = (r_count != 3'd4);
   assign w_fall     = r_sync3 & ~r_sync2;
   assign w_rd_req   = r_rd_pend | w_fall;
   assign w_rd_enter = (r_state == S_RUN) & (w_next == S_RD_MSW);

   always_ff @(posedge mclk or posedge i_rest) begin
      if (i_rest) begin
         r_state <= S_IDLE;
         r_cnt   <= 8'd0;
      end else begin
         r_state <= w_next;
         r_cnt   <= (w_next != r_state) ? 8'd0 : r_cnt + 8'd1;
      end
   end

   always_comb begin
      w_last = 1'b1;
      case (r_state)
         S_RST_LO:              w_last = (r_cnt == LP_RST_LO);
         S_RST_HI:              w_last = (r_cnt == LP_RST_HI);
         S_WADR, S_WVAL:        w_last = (r_cnt == LP_CS);
         S_WADR_GAP,S_WVAL_GAP: w_last = (r_cnt == LP_GAP);
         S_SETTLE:              w_last = (r_cnt == LP_SETTLE);
         S_RD_MSW, S_RD_LSW:    w_last = (r_cnt == LP_RD);
         default:               w_last = 1'b1;
      endcase
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:     if (start) w_next = S_RST_LO;
         S_RST_LO:   if (w_last) w_next = S_RST_HI;
         S_RST_HI:   if (w_last) w_next = S_CFG_CHK;
         S_CFG_CHK:  w_next = stop ? S_IDLE : (w_empty ? S_SETTLE : S_WADR);
         S_WADR:     if (w_last) w_next = S_WADR_GAP;
         S_WADR_GAP: if (w_last) w_next = S_WVAL;
         S_WVAL:     if (w_last) w_next = S_WVAL_GAP;
         S_WVAL_GAP: if (w_last) w_next = r_run_mode ? S_RUN : S_CFG_CHK;
         S_SETTLE: begin
            if (stop)        w_next = S_IDLE;
            else if (w_last) w_next = S_RUN;
         end
         S_RUN: begin
            if (stop)          w_next = S_IDLE;
            else if (w_rd_req) w_next = S_RD_MSW;
            else if (!w_empty) w_next = S_WADR;
         end
         S_RD_MSW:   if (w_last) w_next = S_RD_GAP;
         S_RD_GAP:   w_next = S_RD_LSW;
         S_RD_LSW:   if (w_last) w_next = S_RD_DONE;
         S_RD_DONE:  w_next = S_RUN;
         default:    w_next = S_IDLE;
      endcase
   end

   always_comb begin
      cs_n      = 1'b1;
      r_n_w     = 1'b1;
      o_rest_n  = 1'b1;
      adc_oe    = 1'b0;
      adc_dout  = 16'h0000;
      smp_valid = (r_state == S_RD_DONE);
      busy      = (r_state != S_IDLE);
      case (r_state)
         S_RST_LO:   o_rest_n = 1'b0;
         S_WADR:     begin cs_n = 1'b0; adc_oe = 1'b1; adc_dout = r_q_addr[r_rptr]; end
         S_WADR_GAP: begin adc_oe = 1'b1; adc_dout = r_q_addr[r_rptr]; end
         S_WVAL:     begin cs_n = 1'b0; adc_oe = 1'b1; adc_dout = r_q_data[r_rptr]; end
         S_WVAL_GAP: begin adc_oe = 1'b1; adc_dout = r_q_data[r_rptr]; end
         S_RD_MSW, S_RD_LSW: begin cs_n = 1'b0; r_n_w = 1'b0; end
         default:    cs_n = 1'b1;
      endcase
   end

   always_ff @(posedge mclk) begin
      if (w_push) begin
         r_q_addr[r_wptr] <= cfg_addr;
         r_q_data[r_wptr] <= cfg_data;
      end
   end

   always_ff @(posedge mclk or posedge i_rest) begin
      if (i_rest) begin
         r_wptr  <= 2'd0;
         r_rptr  <= 2'd0;
         r_count <= 3'd0;
      end else begin
         if (w_push) r_wptr <= r_wptr + 2'd1;
         if (w_pop)  r_rptr <= r_rptr + 2'd1;
         if (w_push && !w_pop)      r_count <= r_count + 3'd1;
         else if (!w_push && w_pop) r_count <= r_count - 3'd1;
      end
   end

   // A fall arriving on the same edge a pending read is consumed stays pending.
   always_ff @(posedge mclk or posedge i_rest) begin
      if (i_rest) begin
         r_sync1    <= 1'b1;
         r_sync2    <= 1'b1;
         r_sync3    <= 1'b1;
         r_rd_pend  <= 1'b0;
         r_ovf      <= 8'd0;
         r_run_mode <= 1'b0;
         r_msw      <= 16'h0000;
         r_smp_data <= 32'h0000_0000;
      end else begin
         r_sync1 <= drdy_n;
         r_sync2 <= r_sync1;
         r_sync3 <= r_sync2;
         if (w_rd_enter) r_rd_pend <= r_rd_pend & w_fall;
         else            r_rd_pend <= r_rd_pend | w_fall;
         if (w_fall && r_rd_pend && !w_rd_enter && (r_ovf != 8'hFF))
            r_ovf <= r_ovf + 8'd1;
         if (r_state == S_RUN)       r_run_mode <= 1'b1;
         else if (r_state == S_IDLE) r_run_mode <= 1'b0;
         if ((r_state == S_RD_MSW) && w_last) r_msw <= adc_din;
         if ((r_state == S_RD_LSW) && w_last) r_smp_data <= {r_msw, adc_din};
      end
   end

   assign smp_data    = r_smp_data;
   assign ovf_cnt     = r_ovf;
   assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ad7760_bus_sched.sv
// Directed bench for ad7760_bus_sched: config drain, reads, arbitration,
// overflow, queue full, mid-operation reset and stop.
module tb_ad7760_bus_sched;

   localparam logic [3:0] ST_IDLE   = 4'd0;
   localparam logic [3:0] ST_WVAL   = 4'd6;
   localparam logic [3:0] ST_RUN    = 4'd9;
   localparam logic [3:0] ST_RD_LSW = 4'd12;

   logic        mclk, i_rest, start, stop, cfg_valid, cfg_ready;
   logic [15:0] cfg_addr, cfg_data, adc_din, adc_dout;
   logic        drdy_n, adc_oe, cs_n, r_n_w, o_rest_n, smp_valid, busy;
   logic [31:0] smp_data;
   logic [7:0]  ovf_cnt;
   logic [3:0]  o_dbg_state;

   int checks = 0;
   int errors = 0;
   int n, lo, pulses, first;
   int n2;
   logic [31:0] got;

   ad7760_bus_sched dut (
      .mclk(mclk), .i_rest(i_rest), .start(start), .stop(stop),
      .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .drdy_n(drdy_n), .adc_din(adc_din),
      .adc_dout(adc_dout), .adc_oe(adc_oe), .cs_n(cs_n), .r_n_w(r_n_w),
      .o_rest_n(o_rest_n), .smp_valid(smp_valid), .smp_data(smp_data),
      .busy(busy), .ovf_cnt(ovf_cnt), .o_dbg_state(o_dbg_state)
   );

   initial mclk = 1'b0;
   always #5 mclk = ~mclk;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge mclk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [15:0] a, input logic [15:0] d);
      cfg_valid = 1'b1;
      cfg_addr  = a;
      cfg_data  = d;
      tick();
      cfg_valid = 1'b0;
   endtask

   // One cs_n word: low window, then the write gap while the bus is still driven.
   task automatic expect_pulse(input string tag, input logic [15:0] exp);
      int w, l, h, bad;
      w = 0; l = 0; h = 0; bad = 0;
      while (cs_n !== 1'b0 && w < 40) begin tick(); w++; end
      chk({tag, "_cs_low"}, {31'd0, cs_n}, 32'd0);
      while (cs_n === 1'b0 && l < 40) begin
         if (adc_dout !== exp || adc_oe !== 1'b1 || r_n_w !== 1'b1) bad++;
         l++;
         tick();
      end
      while (cs_n === 1'b1 && adc_oe === 1'b1 && h < 40) begin
         if (adc_dout !== exp) bad++;
         h++;
         tick();
      end
      chk({tag, "_lo_len"}, l, 32'd8);
      chk({tag, "_gap_len"}, h, 32'd8);
      chk({tag, "_dout_bad"}, bad, 32'd0);
   endtask

   task automatic expect_pair(input string tag, input logic [15:0] a, input logic [15:0] d);
      expect_pulse({tag, "_adr"}, a);
      expect_pulse({tag, "_val"}, d);
   endtask

   task automatic wait_run(output int cyc, output int cs_lo);
      cyc = 0; cs_lo = 0;
      while (o_dbg_state !== ST_RUN && cyc < 60) begin
         tick();
         cyc++;
         if (cs_n === 1'b0) cs_lo++;
      end
   endtask

   initial begin
      i_rest = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0;
      cfg_addr = '0; cfg_data = '0; drdy_n = 1'b1; adc_din = '0;
      repeat (3) tick();
      chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("rst_r_n_w", {31'd0, r_n_w}, 32'd1);
      chk("rst_rest_n", {31'd0, o_rest_n}, 32'd1);
      chk("rst_oe", {31'd0, adc_oe}, 32'd0);
      chk("rst_dout", {16'd0, adc_dout}, 32'd0);
      chk("rst_smp", {31'd0, smp_valid}, 32'd0);
      chk("rst_smp_data", smp_data, 32'd0);
      chk("rst_ovf", {24'd0, ovf_cnt}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_ready", {31'd0, cfg_ready}, 32'd1);
      i_rest = 1'b0;
      tick();

      // Initial configuration with two queued pairs
      push(16'h0001, 16'h0000);
      push(16'h0002, 16'h0022);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("rest_lo_c0", {31'd0, o_rest_n}, 32'd0);
      chk("busy_cfg", {31'd0, busy}, 32'd1);
      tick();
      chk("rest_lo_c1", {31'd0, o_rest_n}, 32'd0);
      tick();
      chk("rest_hi", {31'd0, o_rest_n}, 32'd1);
      expect_pair("cfg0", 16'h0001, 16'h0000);
      expect_pair("cfg1", 16'h0002, 16'h0022);
      wait_run(n, lo);
      chk("settle_len", n, 32'd7);
      chk("busy_run", {31'd0, busy}, 32'd1);

      // Conversion read: sample 8 cycles after the raw drdy_n fall
      adc_din = 16'h1234;
      drdy_n  = 1'b0;
      first = 0; pulses = 0; lo = 0; n = 0;
      for (int i = 1; i <= 12; i++) begin
         tick();
         if (i == 3) drdy_n = 1'b1;
         if (i == 5) adc_din = 16'h5678;
         if (cs_n === 1'b0) lo++;
         if (r_n_w === 1'b0 && cs_n !== 1'b0) n++;
         if (smp_valid === 1'b1) begin
            pulses++;
            if (first == 0) begin first = i; got = smp_data; end
         end
         if (i == 9) chk("smp_hold", smp_data, 32'h1234_5678);
      end
      chk("rd_latency", first, 32'd8);
      chk("rd_data", got, 32'h1234_5678);
      chk("rd_pulses", pulses, 32'd1);
      chk("rd_cs_lo", lo, 32'd4);
      chk("rnw_outside_cs", n, 32'd0);

      // Arbitration: drdy_n falls 3 cycles into WADR
      adc_din = 16'hBEEF;
      push(16'h0002, 16'h009B);
      fork
         expect_pair("arb", 16'h0002, 16'h009B);
         begin
            n2 = 0;
            while (cs_n !== 1'b0 && n2 < 40) begin tick(); n2++; end
            repeat (3) tick();
            drdy_n = 1'b0;
            repeat (4) tick();
            drdy_n = 1'b1;
         end
      join
      tick();
      chk("arb_rd_cs", {31'd0, cs_n}, 32'd0);
      chk("arb_rd_rnw", {31'd0, r_n_w}, 32'd0);
      n = 0;
      while (smp_valid !== 1'b1 && n < 20) begin tick(); n++; end
      chk("arb_smp_data", smp_data, 32'hBEEF_BEEF);
      chk("arb_ovf", {24'd0, ovf_cnt}, 32'd0);

      // Overflow: two drdy_n falls inside one write pair
      adc_din = 16'h0F0F;
      push(16'h0004, 16'h0044);
      fork
         expect_pair("ovf", 16'h0004, 16'h0044);
         begin
            n2 = 0;
            while (cs_n !== 1'b0 && n2 < 40) begin tick(); n2++; end
            repeat (2) tick();
            drdy_n = 1'b0;
            repeat (3) tick();
            drdy_n = 1'b1;
            repeat (3) tick();
            drdy_n = 1'b0;
            repeat (3) tick();
            drdy_n = 1'b1;
         end
      join
      chk("ovf_cnt", {24'd0, ovf_cnt}, 32'd1);
      pulses = 0; got = '0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (smp_valid === 1'b1) begin pulses++; got = smp_data; end
      end
      chk("ovf_pulses", pulses, 32'd1);
      chk("ovf_smp_data", got, 32'h0F0F_0F0F);

      // Stop from RUN, then fill the queue while idle
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_idle_busy", {31'd0, busy}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         cfg_valid = 1'b1;
         cfg_addr  = 16'h0010 + 16'(k);
         cfg_data  = 16'h0100 + 16'(k);
         chk($sformatf("q_ready%0d", k), {31'd0, cfg_ready}, (k < 4) ? 32'd1 : 32'd0);
         tick();
      end
      cfg_valid = 1'b0;
      chk("q_full", {31'd0, cfg_ready}, 32'd0);
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 0; k < 4; k++)
         expect_pair($sformatf("q%0d", k), 16'h0010 + 16'(k), 16'h0100 + 16'(k));
      wait_run(n, lo);
      chk("q_settle_len", n, 32'd7);

      // Asynchronous reset in the middle of WVAL
      push(16'h0003, 16'h0033);
      n = 0;
      while (o_dbg_state !== ST_WVAL && n < 40) begin tick(); n++; end
      chk("reach_wval_cs", {31'd0, cs_n}, 32'd0);
      tick();
      tick();
      #2;
      i_rest = 1'b1;
      #1;
      chk("arst_cs_n", {31'd0, cs_n}, 32'd1);
      chk("arst_oe", {31'd0, adc_oe}, 32'd0);
      chk("arst_rest_n", {31'd0, o_rest_n}, 32'd1);
      chk("arst_busy", {31'd0, busy}, 32'd0);
      chk("arst_ovf", {24'd0, ovf_cnt}, 32'd0);
      chk("arst_dout", {16'd0, adc_dout}, 32'd0);
      chk("arst_ready", {31'd0, cfg_ready}, 32'd1);
      tick();
      i_rest = 1'b0;
      tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      wait_run(n, lo);
      chk("arst_empty_run_len", n, 32'd11);
      chk("arst_empty_cs_lo", lo, 32'd0);

      // Stop raised during RD_LSW: sample still delivered, then IDLE
      adc_din = 16'hCAFE;
      drdy_n  = 1'b0;
      n = 0;
      while (o_dbg_state !== ST_RD_LSW && n < 20) begin tick(); n++; end
      drdy_n = 1'b1;
      stop   = 1'b1;
      n = 0;
      while (smp_valid !== 1'b1 && n < 10) begin tick(); n++; end
      chk("stop_smp_valid", {31'd0, smp_valid}, 32'd1);
      chk("stop_smp_data", smp_data, 32'hCAFE_CAFE);
      tick();
      tick();
      chk("stop_busy", {31'd0, busy}, 32'd0);
      chk("stop_state", {28'd0, o_dbg_state}, {28'd0, ST_IDLE});
      stop = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
